// File: rtl/cmp_share_pkg.sv
// Shared constants for the cmp_share_arbiter block: FSM encoding, default operand width
// and requester ids.
package cmp_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned DEF_WIDTH = 4;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/cmp_share_arbiter_if.sv
// Requester, response and status signals of cmp_share_arbiter.
// CMP_SHARE_STATS_EN adds the gcnt0/gcnt1 grant counters.
interface cmp_share_arbiter_if #(
    parameter int unsigned WIDTH = cmp_share_pkg::DEF_WIDTH,
    parameter int unsigned SAT_W = 8
);
    logic             req0;
    logic [0:WIDTH-1] a0;
    logic [0:WIDTH-1] b0;
    logic             sgn0;
    logic             req1;
    logic [0:WIDTH-1] a1;
    logic [0:WIDTH-1] b1;
    logic             sgn1;
    logic             gnt0;
    logic             gnt1;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic             rsp_g;
    logic             rsp_l;
    logic             rsp_e;
    logic             busy;

`ifdef CMP_SHARE_STATS_EN
    logic [SAT_W-1:0] gcnt0;
    logic [SAT_W-1:0] gcnt1;

    modport master (
        output req0, a0, b0, sgn0, req1, a1, b1, sgn1, rsp_ready,
        input  gnt0, gnt1, rsp_valid, rsp_id, rsp_g, rsp_l, rsp_e, busy, gcnt0, gcnt1
    );

    modport slave (
        input  req0, a0, b0, sgn0, req1, a1, b1, sgn1, rsp_ready,
        output gnt0, gnt1, rsp_valid, rsp_id, rsp_g, rsp_l, rsp_e, busy, gcnt0, gcnt1
    );
`else
    modport master (
        output req0, a0, b0, sgn0, req1, a1, b1, sgn1, rsp_ready,
        input  gnt0, gnt1, rsp_valid, rsp_id, rsp_g, rsp_l, rsp_e, busy
    );

    modport slave (
        input  req0, a0, b0, sgn0, req1, a1, b1, sgn1, rsp_ready,
        output gnt0, gnt1, rsp_valid, rsp_id, rsp_g, rsp_l, rsp_e, busy
    );
`endif

endinterface

// File: rtl/cmp_core.sv
// Combinational magnitude comparator; bit 0 is the MSB and, when sgn = 1, the sign bit.
module cmp_core #(
    parameter int unsigned WIDTH = cmp_share_pkg::DEF_WIDTH
) (
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic             sgn,
    output logic             g,
    output logic             l,
    output logic             e
);

    logic lt;

    always_comb begin
        e = (a == b);
        // Differing sign bits: the negative operand is the smaller one.
        if (sgn && (a[0] != b[0])) begin
            lt = a[0];
        end else begin
            lt = (a < b);
        end
        l = lt;
        g = !lt && !e;
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin share of one cmp_core between two requesters, one operation in flight.
// CMP_SHARE_STATS_EN adds saturating per-requester grant counters.
module cmp_share_arbiter
    import cmp_share_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SAT_W = 8
) (
    input logic                clk,
    input logic                rst,
    cmp_share_arbiter_if.slave bus
);

    state_e state_q, state_d;

    logic [0:WIDTH-1] a_q, a_d;
    logic [0:WIDTH-1] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_g_q, rsp_g_d;
    logic             rsp_l_q, rsp_l_d;
    logic             rsp_e_q, rsp_e_d;

    logic winner;
    logic core_g, core_l, core_e;

    cmp_core #(
        .WIDTH(WIDTH)
    ) u_cmp_core (
        .a  (a_q),
        .b  (b_q),
        .sgn(sgn_q),
        .g  (core_g),
        .l  (core_l),
        .e  (core_e)
    );

    // A tie goes to whoever did not win last time.
    always_comb begin
        if (bus.req0 && bus.req1) begin
            winner = (last_q == ID_REQ0) ? ID_REQ1 : ID_REQ0;
        end else if (bus.req1) begin
            winner = ID_REQ1;
        end else begin
            winner = ID_REQ0;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sgn_d       = sgn_q;
        id_d        = id_q;
        last_d      = last_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_g_d     = rsp_g_q;
        rsp_l_d     = rsp_l_q;
        rsp_e_d     = rsp_e_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    a_d     = (winner == ID_REQ1) ? bus.a1 : bus.a0;
                    b_d     = (winner == ID_REQ1) ? bus.b1 : bus.b0;
                    sgn_d   = (winner == ID_REQ1) ? bus.sgn1 : bus.sgn0;
                    id_d    = winner;
                    last_d  = winner;
                    gnt0_d  = (winner == ID_REQ0);
                    gnt1_d  = (winner == ID_REQ1);
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                rsp_g_d     = core_g;
                rsp_l_d     = core_l;
                rsp_e_d     = core_e;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            id_q        <= ID_REQ0;
            last_q      <= ID_REQ1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_g_q     <= 1'b0;
            rsp_l_q     <= 1'b0;
            rsp_e_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sgn_q       <= sgn_d;
            id_q        <= id_d;
            last_q      <= last_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_g_q     <= rsp_g_d;
            rsp_l_q     <= rsp_l_d;
            rsp_e_q     <= rsp_e_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_g     = rsp_g_q;
    assign bus.rsp_l     = rsp_l_q;
    assign bus.rsp_e     = rsp_e_q;
    assign bus.busy      = (state_q != ST_IDLE);

`ifdef CMP_SHARE_STATS_EN
    logic [SAT_W-1:0] gcnt0_q, gcnt0_d;
    logic [SAT_W-1:0] gcnt1_q, gcnt1_d;

    always_comb begin
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        if (gnt0_q && (gcnt0_q != {SAT_W{1'b1}})) begin
            gcnt0_d = gcnt0_q + SAT_W'(1);
        end
        if (gnt1_q && (gcnt1_q != {SAT_W{1'b1}})) begin
            gcnt1_d = gcnt1_q + SAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

    assign bus.gcnt0 = gcnt0_q;
    assign bus.gcnt1 = gcnt1_q;
`else
    logic [SAT_W-1:0] unused_sat_w;
    assign unused_sat_w = '0;
`endif

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Scoreboard bench for cmp_share_arbiter: directed operations push expected grants and
// responses; negedge monitors pop and compare. Stats checks need CMP_SHARE_STATS_EN.
module tb_cmp_share_arbiter;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned SAT_W = 2;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic       gnt_exp[$];
    logic [3:0] rsp_exp[$];

    cmp_share_arbiter_if #(.WIDTH(WIDTH), .SAT_W(SAT_W)) bus ();

    cmp_share_arbiter #(
        .WIDTH(WIDTH),
        .SAT_W(SAT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Grant monitor
    always @(negedge clk) begin
        if (!rst && (bus.gnt0 || bus.gnt1)) begin
            if (gnt_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected grant: got gnt0=%0b gnt1=%0b, expected none",
                         bus.gnt0, bus.gnt1);
            end else begin
                chk("grant", {bus.gnt0, bus.gnt1}, gnt_exp.pop_front() ? 2'b01 : 2'b10);
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid) begin
            chk("rsp one-hot", 32'(bus.rsp_g) + 32'(bus.rsp_l) + 32'(bus.rsp_e), 1);
            if (bus.rsp_ready) begin
                if (rsp_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected response: got id=%0b gle=%b%b%b, expected none",
                             bus.rsp_id, bus.rsp_g, bus.rsp_l, bus.rsp_e);
                end else begin
                    chk("rsp {id,g,l,e}", {bus.rsp_id, bus.rsp_g, bus.rsp_l, bus.rsp_e},
                        rsp_exp.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic drive(input bit id, input bit req, input logic [3:0] a, input logic [3:0] b,
                         input bit sgn);
        if (id) begin
            bus.req1 = req; bus.a1 = a; bus.b1 = b; bus.sgn1 = sgn;
        end else begin
            bus.req0 = req; bus.a0 = a; bus.b0 = b; bus.sgn0 = sgn;
        end
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            n++;
            if (bus.gnt0 || bus.gnt1) return;
        end
        checks++;
        errors++;
        $display("FAIL grant timeout: got no gnt in 20 cycles, expected a gnt");
        n = -1;
    endtask

    // Single operation from IDLE with rsp_ready = 1; gle = {g,l,e}.
    task automatic do_op(input bit id, input logic [3:0] a, input logic [3:0] b,
                         input bit sgn, input logic [2:0] gle);
        int n;
        gnt_exp.push_back(id);
        rsp_exp.push_back({id, gle});
        @(posedge clk); #1;
        drive(id, 1'b1, a, b, sgn);
        wait_gnt(n);
        chk("gnt latency", n, 2);
        @(posedge clk); #1;
        drive(id, 1'b0, a, b, sgn);
        @(negedge clk);
        chk("rsp_valid latency", bus.rsp_valid, 1);
        chk("busy in RESP", bus.busy, 1);
        @(negedge clk);
        chk("idle after ready", bus.busy, 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " outputs"},
            {bus.gnt0, bus.gnt1, bus.rsp_valid, bus.rsp_id, bus.rsp_g, bus.rsp_l, bus.rsp_e,
             bus.busy}, 8'h00);
`ifdef CMP_SHARE_STATS_EN
        chk({name, " gcnt"}, {bus.gcnt0, bus.gcnt1}, 4'h0);
`endif
    endtask

    initial begin
        int n;
        int prev;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        #1 rst = 1'b1;
        #2 chk_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Basic unsigned and signed compares.
        do_op(1'b0, 4'b0101, 4'b0011, 1'b0, 3'b100);
        do_op(1'b1, 4'b1110, 4'b0001, 1'b1, 3'b010);
        do_op(1'b1, 4'b1110, 4'b0001, 1'b0, 3'b100);
        do_op(1'b1, 4'b1000, 4'b1111, 1'b1, 3'b010);
        do_op(1'b1, 4'b0111, 4'b1000, 1'b1, 3'b100);
        do_op(1'b0, 4'b0111, 4'b1000, 1'b0, 3'b010);

        // Round robin from a fresh reset: 0,1,0,1 three cycles apart.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        gnt_exp.push_back(1'b0); rsp_exp.push_back(4'b0100);
        gnt_exp.push_back(1'b1); rsp_exp.push_back(4'b1010);
        gnt_exp.push_back(1'b0); rsp_exp.push_back(4'b0100);
        gnt_exp.push_back(1'b1); rsp_exp.push_back(4'b1010);
        drive(1'b0, 1'b1, 4'b0101, 4'b0011, 1'b0);
        drive(1'b1, 1'b1, 4'b1110, 4'b0001, 1'b1);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(n);
            if (k > 0) chk("rr spacing", cyc - prev, 3);
            prev = cyc;
        end
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rr idle", bus.busy, 0);

        // Backpressure: hold the result for 5 cycles while req1 waits.
        gnt_exp.push_back(1'b0); rsp_exp.push_back(4'b0010);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        drive(1'b0, 1'b1, 4'b0010, 4'b0111, 1'b0);
        wait_gnt(n);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        gnt_exp.push_back(1'b1); rsp_exp.push_back(4'b1001);
        drive(1'b1, 1'b1, 4'b0011, 4'b0011, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall valid/busy", {bus.rsp_valid, bus.busy}, 2'b11);
            chk("stall fields", {bus.rsp_id, bus.rsp_g, bus.rsp_l, bus.rsp_e}, 4'b0010);
            chk("stall no gnt", {bus.gnt0, bus.gnt1}, 2'b00);
            @(negedge clk);
        end
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("released valid/busy", {bus.rsp_valid, bus.busy}, 2'b00);
        wait_gnt(n);
        chk("gnt after release", n, 1);
        @(posedge clk); #1 bus.req1 = 1'b0;
        @(negedge clk);
        chk("post-stall rsp_valid", bus.rsp_valid, 1);
        @(negedge clk);

        // Reset in CMP drops the in-flight result; req0 wins afterwards.
        gnt_exp.push_back(1'b1);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 4'b0001, 4'b0010, 1'b0);
        wait_gnt(n);
        #1 rst = 1'b1;
        #1 chk_all_zero("mid-op reset");
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        gnt_exp.push_back(1'b0); rsp_exp.push_back(4'b0010);
        drive(1'b0, 1'b1, 4'b1001, 4'b0100, 1'b1);
        @(posedge clk); #1 rst = 1'b0;
        wait_gnt(n);
        chk("post-reset gnt latency", n, 2);
        @(posedge clk); #1 bus.req0 = 1'b0;
        @(negedge clk);
        chk("post-reset rsp_valid", bus.rsp_valid, 1);
        @(negedge clk);

        // Equality, then saturation of the grant counter.
        do_op(1'b0, 4'b1000, 4'b1000, 1'b1, 3'b001);
`ifdef CMP_SHARE_STATS_EN
        chk("gcnt0 after 2", bus.gcnt0, 2);
        chk("gcnt1 after 2", bus.gcnt1, 0);
`endif
        do_op(1'b0, 4'b0000, 4'b1111, 1'b0, 3'b010);
        do_op(1'b0, 4'b0000, 4'b1111, 1'b1, 3'b100);
        do_op(1'b0, 4'b0111, 4'b0111, 1'b0, 3'b001);
`ifdef CMP_SHARE_STATS_EN
        chk("gcnt0 saturated", bus.gcnt0, 3);
        chk("gcnt1 untouched", bus.gcnt1, 0);
`endif

        repeat (3) @(negedge clk);
        chk("grant queue drained", gnt_exp.size(), 0);
        chk("response queue drained", rsp_exp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
